// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter.
// Sequence: inhibit the clock, request-to-send, shift 8 data bits plus odd
// parity and stop on device falling edges, then sample the device ACK.
// Optional build macro PS2_HOST_TX_TIMEOUT_EN adds a watchdog that aborts a
// transfer when the device stops clocking for TIMEOUT_CYCLES cycles.
// Handshake: tx_start is a single-cycle request, accepted only when
// tx_busy=0 and the FSM is idle; tx_busy stays high from the cycle after
// acceptance until the cycle that carries the tx_done / tx_error pulse.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2700,
  parameter int TIMEOUT_CYCLES = 405000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_RTS       = 3'd2,
    S_SHIFT     = 3'd3,
    S_ACK       = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_MAX = INH_W'(INHIBIT_CYCLES);

  state_t           state, state_d;
  logic [1:0]       clk_sync, data_sync;
  logic             clk_prev;
  logic             clk_s, data_s, fall, lines_idle;
  logic [7:0]       data_q;
  logic             parity_q;
  logic             ok_q;
  logic [3:0]       edge_cnt;
  logic [INH_W-1:0] inh_cnt;
  logic [2:0]       bit_idx;
  logic             timeout;

  assign clk_s      = clk_sync[1];
  assign data_s     = data_sync[1];
  assign fall       = clk_prev & ~clk_s;
  assign lines_idle = clk_s & data_s;
  assign bit_idx    = edge_cnt[2:0] - 3'd1;
  assign dbg_state  = state;

  // Two-flop synchronizers for both lines plus the previous clock sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
      clk_prev  <= clk_sync[1];
    end
  end

`ifdef PS2_HOST_TX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);
  logic [WD_W-1:0] wd_cnt;
  logic            wd_active;

  assign wd_active = (state == S_RTS) || (state == S_SHIFT) ||
                     (state == S_ACK) || (state == S_WAIT_IDLE);
  assign timeout   = wd_active && (wd_cnt == WD_MAX);

  // Watchdog: counts while waiting on the device, restarts on each edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (!wd_active || fall || timeout) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  // Watchdog compiled out: the FSM waits for the device indefinitely.
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  // Next-state logic; a watchdog expiry always returns to IDLE.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:      if (tx_start) state_d = S_INHIBIT;
      S_INHIBIT:   if (inh_cnt == INH_MAX) state_d = S_RTS;
      S_RTS:       if (fall) state_d = S_SHIFT;
      S_SHIFT:     if (fall && (edge_cnt == 4'd9)) state_d = S_ACK;
      S_ACK:       if (fall) state_d = S_WAIT_IDLE;
      S_WAIT_IDLE: if (lines_idle) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
    if (timeout) state_d = S_IDLE;
  end

  // Datapath: byte/parity latch, inhibit timer, edge counter, ACK flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q   <= 8'h00;
      parity_q <= 1'b0;
      ok_q     <= 1'b0;
      edge_cnt <= 4'd0;
      inh_cnt  <= '0;
    end else begin
      if (state == S_IDLE && tx_start) begin
        data_q   <= tx_data;
        parity_q <= ~^tx_data;
        ok_q     <= 1'b0;
        edge_cnt <= 4'd0;
      end else if (fall && (state == S_RTS || state == S_SHIFT || state == S_ACK)) begin
        edge_cnt <= edge_cnt + 4'd1;
      end
      if (state == S_ACK && fall) ok_q <= ~data_s;
      inh_cnt <= (state == S_INHIBIT) ? inh_cnt + 1'b1 : '0;
    end
  end

  // Output decode from registered state; the data line only moves after a
  // registered edge count update, i.e. while the device holds clock low.
  always_comb begin
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    tx_busy     = (state != S_IDLE);
    tx_done     = 1'b0;
    tx_error    = 1'b0;
    case (state)
      S_INHIBIT: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = (inh_cnt == INH_MAX);
      end
      S_RTS:   ps2_data_oe = 1'b1;
      S_SHIFT: begin
        if (edge_cnt >= 4'd1 && edge_cnt <= 4'd8) ps2_data_oe = ~data_q[bit_idx];
        else if (edge_cnt == 4'd9)                ps2_data_oe = ~parity_q;
        else                                      ps2_data_oe = 1'b0;
      end
      S_WAIT_IDLE: begin
        if (lines_idle) begin
          tx_busy  = 1'b0;
          tx_done  = ok_q;
          tx_error = ~ok_q;
        end
      end
      default: ;
    endcase
    if (timeout) begin
      ps2_clk_oe  = 1'b0;
      ps2_data_oe = 1'b0;
      tx_busy     = 1'b0;
      tx_done     = 1'b0;
      tx_error    = 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with an open-drain line
// model and a behavioural PS/2 device that clocks the byte in.
module tb_ps2_host_tx;

  localparam int HALF   = 409;   // device half period, ~33 kHz at 27 MHz
  localparam int INH    = 2700;
  localparam int TMO    = 1000;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RTS  = 3'd2;

  typedef struct {
    logic [7:0] data;
    bit         ack;
    logic [7:0] exp_byte;
    logic       exp_par;
    int         exp_done;
    int         exp_err;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_error;
  logic [2:0] dbg_state;
  logic       clk_line, data_line;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int inh_run = 0, last_inh = 0, high_viol = 0, cyc = 0;
  logic prev_data_oe = 1'b0;

  // Open-drain lines with pull-ups.
  assign clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign data_line = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .ps2_clk_in  (clk_line),
    .ps2_data_in (data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_error    (tx_error),
    .dbg_state   (dbg_state)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitors: pulse counts, inhibit length, data moving while clock high.
  always @(negedge clk) begin
    if (tx_done)              done_cnt <= done_cnt + 1;
    if (tx_error)             err_cnt  <= err_cnt + 1;
    if (tx_done && tx_error)  both_cnt <= both_cnt + 1;
    if (ps2_clk_oe && !ps2_data_oe)     inh_run  <= inh_run + 1;
    else if (ps2_clk_oe && ps2_data_oe) last_inh <= inh_run;
    else                                inh_run  <= 0;
    if (rst_n && tx_busy && (ps2_data_oe != prev_data_oe) && clk_line)
      high_viol <= high_viol + 1;
    prev_data_oe <= ps2_data_oe;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not reach its end");
    $fatal(1, "global timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_tx(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  // Device: wait for request-to-send, then clock n_edges pulses, sampling
  // data on each rising edge; drive ACK low around edge 11 when asked.
  task automatic device_xfer(input int n_edges, input bit ack, output logic [9:0] bits);
    int t;
    bits = '0;
    t = 0;
    while (!(clk_line && !data_line && tx_busy) && t < 6000) begin
      @(negedge clk);
      t++;
    end
    check("rts_seen", 32'(t < 6000), 32'd1);
    if (t >= 6000) return;
    wait_cycles(40);
    for (int e = 1; e <= n_edges; e++) begin
      if (e == 11) dev_data_low = ack;
      dev_clk_low = 1'b1;
      wait_cycles(HALF);
      dev_clk_low = 1'b0;
      if (e <= 10) bits[e-1] = data_line;
      wait_cycles(HALF);
      if (e == 11) dev_data_low = 1'b0;
    end
  endtask

  initial begin
    vec_t       vecs[3];
    logic [9:0] bits;
    int         d0, e0, t, c0, c1;

    vecs[0] = '{8'hF4, 1'b1, 8'hF4, 1'b0, 1, 0};
    vecs[1] = '{8'hFF, 1'b1, 8'hFF, 1'b1, 1, 0};
    vecs[2] = '{8'hE8, 1'b0, 8'hE8, 1'b1, 0, 1};

    // Reset state.
    rst_n = 1'b0;
    wait_cycles(5);
    check("rst_clk_oe",  ps2_clk_oe,  0);
    check("rst_data_oe", ps2_data_oe, 0);
    check("rst_busy",    tx_busy,     0);
    check("rst_done",    tx_done,     0);
    check("rst_error",   tx_error,    0);
    check("rst_state",   dbg_state,   ST_IDLE);
    rst_n = 1'b1;
    wait_cycles(5);

    // Table-driven transfers.
    for (int i = 0; i < 3; i++) begin
      d0 = done_cnt;
      e0 = err_cnt;
      start_tx(vecs[i].data);
      device_xfer(11, vecs[i].ack, bits);
      wait_cycles(20);
      check($sformatf("v%0d_byte", i),   bits[7:0], vecs[i].exp_byte);
      check($sformatf("v%0d_parity", i), bits[8],   vecs[i].exp_par);
      check($sformatf("v%0d_stop", i),   bits[9],   1);
      check($sformatf("v%0d_inhibit", i), last_inh, INH);
      check($sformatf("v%0d_done", i),   done_cnt - d0, vecs[i].exp_done);
      check($sformatf("v%0d_error", i),  err_cnt - e0,  vecs[i].exp_err);
      check($sformatf("v%0d_busy", i),   tx_busy, 0);
      check($sformatf("v%0d_oe", i),     {ps2_clk_oe, ps2_data_oe}, 0);
    end

    // Second request while busy is ignored.
    d0 = done_cnt;
    start_tx(8'hF4);
    wait_cycles(10);
    check("busy_during", tx_busy, 1);
    start_tx(8'hF3);
    device_xfer(11, 1'b1, bits);
    wait_cycles(20);
    check("ign_byte", bits[7:0], 8'hF4);
    check("ign_done", done_cnt - d0, 1);
    wait_cycles(200);
    check("ign_state", dbg_state, ST_IDLE);
    check("ign_clk_oe", ps2_clk_oe, 0);

    // Reset after edge 5, then a clean retry.
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(8'hF4);
    device_xfer(5, 1'b1, bits);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_clk_oe",  ps2_clk_oe,  0);
    check("mid_rst_data_oe", ps2_data_oe, 0);
    check("mid_rst_busy",    tx_busy,     0);
    check("mid_rst_state",   dbg_state,   ST_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cycles(2000);
    check("mid_rst_no_done",  done_cnt - d0, 0);
    check("mid_rst_no_error", err_cnt - e0,  0);
    d0 = done_cnt;
    start_tx(8'hF4);
    device_xfer(11, 1'b1, bits);
    wait_cycles(20);
    check("retry_byte", bits[7:0], 8'hF4);
    check("retry_done", done_cnt - d0, 1);

    // Silent device after RTS.
    e0 = err_cnt;
    start_tx(8'h55);
    t = 0;
    while (dbg_state != ST_RTS && t < 4000) begin
      @(negedge clk);
      t++;
    end
    check("silent_rts_seen", 32'(t < 4000), 1);
    c0 = cyc;
`ifdef PS2_HOST_TX_TIMEOUT_EN
    t = 0;
    while (!tx_error && t < 2000) begin
      @(negedge clk);
      t++;
    end
    c1 = cyc;
    check("tmo_seen",    32'(t < 2000), 1);
    check("tmo_latency", c1 - c0, TMO);
    check("tmo_oe",      {ps2_clk_oe, ps2_data_oe}, 0);
    check("tmo_busy",    tx_busy, 0);
    wait_cycles(5);
    check("tmo_err_cnt", err_cnt - e0, 1);
    check("tmo_state",   dbg_state, ST_IDLE);
`else
    wait_cycles(1500);
    c1 = cyc;
    check("wait_elapsed", 32'(c1 - c0 >= 1500), 1);
    check("wait_busy",    tx_busy, 1);
    check("wait_state",   dbg_state, ST_RTS);
    check("wait_no_err",  err_cnt - e0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_cycles(5);
`endif

    check("done_error_overlap", both_cnt, 0);
    check("data_moved_clk_high", high_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 2700, is the number of clk cycles the host holds PS/2 clock low before request-to-send (100 us at 27 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 405000, is the watchdog limit in clk cycles (15 ms at 27 MHz).
REQ-003 clk  input  1  system clock (27 MHz).
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 tx_start  input  1  one-cycle request to transmit tx_data.
REQ-006 tx_data  input  8  command byte to the device.
REQ-007 ps2_clk_in  input  1  PS/2 clock line level (asynchronous).
REQ-008 ps2_data_in  input  1  PS/2 data line level (asynchronous).
REQ-009 ps2_clk_oe  output  1  1 = drive PS/2 clock low, 0 = release.
REQ-010 ps2_data_oe  output  1  1 = drive PS/2 data low, 0 = release.
REQ-011 tx_busy  output  1  transfer in progress.
REQ-012 tx_done  output  1  one-cycle pulse, byte acknowledged by the device.
REQ-013 tx_error  output  1  one-cycle pulse, NACK or timeout.

Function
REQ-014 ps2_clk_in and ps2_data_in SHALL pass through 2-flop synchronizers; a falling edge is sync_prev=1 and sync_cur=0.
REQ-015 States SHALL be IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE.
REQ-016 IDLE: tx_start=1 latches tx_data, computes odd parity (~^tx_data), clears the edge counter, asserts tx_busy the next cycle, and enters INHIBIT.
REQ-017 tx_start SHALL be ignored while tx_busy=1.
REQ-018 INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles, then ps2_data_oe=1 (start bit 0) with ps2_clk_oe held 1 for one more cycle, then RTS.
REQ-019 RTS: ps2_clk_oe=0 and ps2_data_oe=1; the first device falling edge enters SHIFT with edge count 1.
REQ-020 SHIFT: on falling edge k, ps2_data_oe SHALL equal the inverse of data bit k-1 for k=1..8 (LSB first), the inverse of parity for k=9, and 0 (stop, line released) for k=10.
REQ-021 Data SHALL change only on the cycle after a detected falling edge, never while the clock is high.
REQ-022 ACK: on falling edge 11, synced data=0 is ACK and sets an ok flag; synced data=1 is NACK. Either case enters WAIT_IDLE.
REQ-023 WAIT_IDLE: once both synced lines are 1, pulse tx_done (ok) or tx_error (NACK) for one cycle, deassert tx_busy in the same cycle, and return to IDLE.
REQ-024 tx_done and tx_error SHALL never assert in the same cycle.
REQ-025 In IDLE both oe outputs SHALL be 0.

Reset
REQ-026 rst_n=0 SHALL immediately force state=IDLE, ps2_clk_oe=0, ps2_data_oe=0, tx_busy=0, tx_done=0, tx_error=0, edge counter=0, timers=0, and synchronizers=1, even mid-transfer.
REQ-027 After a mid-transfer reset, no tx_done or tx_error pulse SHALL follow for the aborted byte.

Configuration
REQ-028 Macro PS2_HOST_TX_TIMEOUT_EN defined: a watchdog counts cycles in RTS, SHIFT, ACK and WAIT_IDLE and resets on every falling edge; reaching TIMEOUT_CYCLES releases both lines, pulses tx_error, clears tx_busy, and returns to IDLE.
REQ-029 Macro PS2_HOST_TX_TIMEOUT_EN undefined: no watchdog logic; the FSM waits for device edges indefinitely.

Verification
REQ-030 tx_data=0xF4, device model clock ~33 kHz (~818 clk cycles per period), ACK driven -> bits sampled on rising edges 0,0,1,0,1,1,1,1, parity 0, stop 1; tx_done pulses once; tx_busy falls.
REQ-031 tx_data=0xFF with ACK -> parity bit 1; ps2_clk_oe low for 2700 cycles before data goes low; tx_done pulses once.
REQ-032 tx_data=0xE8, device leaves data high on edge 11 -> tx_error pulses once; tx_done never asserts.
REQ-033 Second tx_start=0xF3 pulsed during an active 0xF4 transfer -> ignored; only 0xF4 appears on the line.
REQ-034 rst_n pulsed low after edge 5 -> both oe outputs 0 at once, tx_busy=0, no done/error pulse; a new tx_start=0xF4 then completes normally.
REQ-035 With PS2_HOST_TX_TIMEOUT_EN and TIMEOUT_CYCLES=1000, device never clocks after RTS -> tx_error pulses 1000 cycles after RTS entry and both lines are released.
